// File: rtl/alu_sequencer.sv
// Issue controller between decode and a combinational ALU: decodes RV32I reg/imm ALU ops,
// runs shifts serially one bit per cycle, and returns a registered result with flags.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic        req_alt,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic [4:0]  alu_status,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_flags,
    output logic        busy
);

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b1000;
    localparam logic [3:0] OpAnd = 4'b0111;
    localparam logic [3:0] OpOr  = 4'b0110;
    localparam logic [3:0] OpXor = 4'b0100;

    typedef enum logic [1:0] {StIdle, StExec, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic        req_ready_q;
    logic [31:0] alu_a_q, alu_b_q;
    logic [3:0]  alu_op_q;
    logic [2:0]  funct3_q;
    logic        alt_q;
    logic [31:0] shift_q, shift_next;
    logic [4:0]  cnt_q;
    logic [31:0] rsp_data_q;
    logic [4:0]  rsp_flags_q;

    logic        accept;
    logic        req_is_shift;
    logic [3:0]  dec_op;
    logic        slt_bit;
    logic [31:0] exec_data;

    assign req_is_shift = (req_funct3[1:0] == 2'b01);

    always_comb begin
        dec_op = OpAdd;
        case (req_funct3)
            3'b000:         if (req_alt) dec_op = OpSub;
            3'b010, 3'b011: dec_op = OpSub;
            3'b100:         dec_op = OpXor;
            3'b110:         dec_op = OpOr;
            3'b111:         dec_op = OpAnd;
            default:        dec_op = OpAdd;
        endcase
    end

    // Operand signs differ: the answer is fixed by the signs alone, no SUB needed.
    always_comb begin
        slt_bit = alu_result[31];
        if (alu_a_q[31] != alu_b_q[31]) slt_bit = funct3_q[0] ? alu_b_q[31] : alu_a_q[31];
        exec_data = alu_result;
        if (funct3_q == 3'b010 || funct3_q == 3'b011) exec_data = {31'b0, slt_bit};
    end

    always_comb begin
        shift_next = {shift_q[30:0], 1'b0};
        if (funct3_q == 3'b101) shift_next = {alt_q & shift_q[31], shift_q[31:1]};
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    accept  = 1'b1;
                    state_d = req_is_shift ? StShift : StExec;
                end
            end
            StExec:  state_d = StDone;
            StShift: if (cnt_q == 5'd0) state_d = StDone;
            StDone:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OpAdd;
            funct3_q    <= '0;
            alt_q       <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            req_ready_q <= (state_d == StIdle);
            // The decoded op is only presented during the single EXEC cycle.
            alu_op_q    <= accept ? dec_op : OpAdd;
            if (accept) begin
                alu_a_q  <= req_a;
                alu_b_q  <= req_b;
                funct3_q <= req_funct3;
                alt_q    <= req_alt;
                shift_q  <= req_a;
                cnt_q    <= req_b[4:0];
            end
            if (state_q == StExec) begin
                rsp_data_q  <= exec_data;
                rsp_flags_q <= alu_status;
            end
            if (state_q == StShift) begin
                if (cnt_q != 5'd0) begin
                    shift_q <= shift_next;
                    cnt_q   <= cnt_q - 5'd1;
                end else begin
                    rsp_data_q  <= shift_q;
                    rsp_flags_q <= {1'b0, shift_q[31], ~|shift_q, ^shift_q, 1'b0};
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = (state_q == StDone);
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: ALU stub, cycle-level behavioural model,
// directed literal cases and a randomized phase with random response backpressure.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic        req_alt;
    logic [31:0] req_a, req_b;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic [4:0]  alu_status;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_flags;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_alt    (req_alt),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_status (alu_status),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Returns {overflow, negative, zero, parity, carry, result}.
    function automatic logic [36:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b1000: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0111: r = a & b;
            4'b0110: r = a | b;
            4'b0100: r = a ^ b;
            default: r = 32'hDEAD_BEEF;
        endcase
        return {v, r[31], (r == 32'd0), ^r, c, r};
    endfunction

    always_comb {alu_status, alu_result} = alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one request, straight from the instruction semantics.
    task automatic model_op(input logic [2:0] f3, input logic alt, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] d, output logic [4:0] fl,
                            output int lat, output logic [3:0] op, output bit is_exec);
        logic [36:0] x;
        int          sh;
        sh = int'(b[4:0]);
        lat = 2; is_exec = 1'b1; op = 4'b0000;
        case (f3)
            3'b000:  op = alt ? 4'b1000 : 4'b0000;
            3'b010, 3'b011: op = 4'b1000;
            3'b100:  op = 4'b0100;
            3'b110:  op = 4'b0110;
            3'b111:  op = 4'b0111;
            default: op = 4'b0000;
        endcase
        x  = alu_fn(a, b, op);
        d  = x[31:0];
        fl = x[36:32];
        if (f3 == 3'b010) d = {31'b0, ($signed(a) < $signed(b))};
        if (f3 == 3'b011) d = {31'b0, (a < b)};
        if (f3 == 3'b001 || f3 == 3'b101) begin
            is_exec = 1'b0;
            op = 4'b0000;
            if (f3 == 3'b001)  d = a << sh;
            else if (alt)      d = $signed(a) >>> sh;
            else               d = a >> sh;
            fl  = {1'b0, d[31], (d == 32'd0), ^d, 1'b0};
            lat = 2 + sh;
        end
    endtask

    // Cycle-level model: response appears lat edges after accept, holds until taken.
    bit          started = 1'b0;
    bit          m_ready, m_busy, m_valid, m_exec;
    int          m_cnt;
    logic [31:0] m_data, p_data, m_a, m_b;
    logic [4:0]  m_flags, p_flags;
    logic [3:0]  m_op;

    always @(posedge clk) begin
        int          lat;
        bit          ex;
        logic [3:0]  op;
        if (rst) begin
            m_ready = 0; m_busy = 0; m_valid = 0; m_exec = 0; m_cnt = 0;
            m_data = '0; m_flags = '0;
            started = 1'b1;
        end else begin
            m_exec = 0;
            if (m_valid) begin
                if (rsp_ready) begin
                    m_valid = 0; m_busy = 0; m_ready = 1;
                end
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1; m_data = p_data; m_flags = p_flags;
                end
            end else if (m_ready && req_valid) begin
                model_op(req_funct3, req_alt, req_a, req_b, p_data, p_flags, lat, op, ex);
                m_busy = 1; m_ready = 0; m_cnt = lat - 1;
                m_exec = ex; m_op = op; m_a = req_a; m_b = req_b;
            end else begin
                m_ready = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("req_ready", {31'b0, req_ready}, {31'b0, m_ready});
            check("busy", {31'b0, busy}, {31'b0, m_busy});
            check("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
            if (m_valid) begin
                check("rsp_data", rsp_data, m_data);
                check("rsp_flags", {27'b0, rsp_flags}, {27'b0, m_flags});
            end
            if (m_exec) begin
                check("alu_op", {28'b0, alu_op}, {28'b0, m_op});
                check("alu_a", alu_a, m_a);
                check("alu_b", alu_b, m_b);
            end else begin
                check("alu_op_idle", {28'b0, alu_op}, 32'd0);
            end
        end
    end

    bit rsp_rnd = 1'b0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rsp_rnd) rsp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic alt, input logic [31:0] a,
                         input logic [31:0] b);
        int n;
        n = 0;
        req_valid = 1'b1; req_funct3 = f3; req_alt = alt; req_a = a; req_b = b;
        while (!req_ready && n < 200) begin
            step(); n++;
        end
        if (!req_ready) check("issue_timeout", 32'd0, 32'd1);
        step();
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom; req_funct3 = 3'($urandom); req_alt = 1'($urandom);
    endtask

    // Issue with rsp_ready low, measure latency and compare against literals.
    task automatic directed(input string name, input logic [2:0] f3, input logic alt,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_d, input int exp_lat, input bit take);
        int lat;
        rsp_ready = 1'b0;
        issue(f3, alt, a, b);
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            step(); lat++;
        end
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_data"}, rsp_data, exp_d);
        if (take) begin
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        logic [2:0] f3;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_funct3 = '0; req_alt = 1'b0; req_a = '0; req_b = '0;
        repeat (3) step();
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_flags", {27'b0, rsp_flags}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_op", {28'b0, alu_op}, 32'd0);
        rst = 1'b0;
        step();
        check("req_ready_after_rst", {31'b0, req_ready}, 32'd1);

        directed("add_ovf", 3'b000, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 2, 1'b0);
        check("add_ovf_flags43", {30'b0, rsp_flags[4:3]}, 32'd3);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        directed("sub_zero", 3'b000, 1'b1, 32'd5, 32'd5, 32'd0, 2, 1'b0);
        check("sub_zero_flag", {31'b0, rsp_flags[2]}, 32'd1);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        directed("xor", 3'b100, 1'b0, 32'd5, 32'd5, 32'd0, 2, 1'b1);
        directed("or", 3'b110, 1'b1, 32'd5, 32'd5, 32'd5, 2, 1'b1);
        directed("and", 3'b111, 1'b0, 32'd5, 32'd5, 32'd5, 2, 1'b1);
        directed("slt_neg", 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 2, 1'b1);
        directed("sltu_neg", 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 2, 1'b1);
        directed("slt_min", 3'b010, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 2, 1'b1);
        directed("sltu_min", 3'b011, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 2, 1'b1);
        directed("sra4", 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 6, 1'b1);
        directed("srl4", 3'b101, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 6, 1'b1);
        directed("sll0", 3'b001, 1'b0, 32'h1234_5678, 32'h20, 32'h1234_5678, 2, 1'b1);
        directed("sll31", 3'b001, 1'b0, 32'h0000_0003, 32'd31, 32'h8000_0000, 33, 1'b1);

        // Backpressure: response must hold while not taken.
        directed("bp", 3'b000, 1'b0, 32'h100, 32'h23, 32'h123, 2, 1'b0);
        repeat (10) begin
            step();
            check("bp_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_data", rsp_data, 32'h123);
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        check("bp_release_ready", {31'b0, req_ready}, 32'd1);

        // Reset in the middle of a long shift.
        issue(3'b001, 1'b0, 32'h1, 32'd31);
        repeat (4) step();
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_valid", {31'b0, rsp_valid}, 32'd0);
        step();
        check("midrst_valid2", {31'b0, rsp_valid}, 32'd0);
        directed("post_rst_add", 3'b000, 1'b0, 32'd1, 32'd2, 32'd3, 2, 1'b1);

        // Randomized traffic with random response backpressure.
        rsp_rnd = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) step();
            f3 = 3'($urandom);
            issue(f3, 1'($urandom), pick(), pick());
        end
        rsp_rnd = 1'b0;
        step();
        rsp_ready = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            step(); n++;
        end
        check("final_idle", {31'b0, busy}, 32'd0);
        rsp_ready = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
